// File: rtl/cam_pkg.sv
// Shared constants and types for the CAM lookup-or-insert controller.
// Contents: key/index widths, CAM depth, FSM state enum, key, index and
// response payload types.
package cam_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  typedef logic [DATA_W-1:0] key_t;
  typedef logic [IDX_W-1:0]  idx_t;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    CHECK,
    WRITE,
    RESP
  } state_e;

  // Response payload returned to the requester.
  typedef struct packed {
    idx_t index;
    logic hit;
    logic evict;
  } rsp_t;

endpackage

// File: rtl/cam_lookup_ctrl_if.sv
// Request/response handshake bundle between a requester and cam_lookup_ctrl.
// Signals:
//   req_valid / req_ready / req_key   : key request channel
//   rsp_valid / rsp_ready / rsp_data  : index + hit/evict response channel
// Modports: master = requester side, slave = controller side.
interface cam_lookup_ctrl_if;

  logic           req_valid;
  logic           req_ready;
  cam_pkg::key_t  req_key;
  logic           rsp_valid;
  logic           rsp_ready;
  cam_pkg::rsp_t  rsp_data;

  modport master (
    output req_valid,
    output req_key,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_key,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/cam_alloc_ptr.sv
// Round-robin allocation pointer plus saturating occupancy counter.
// Ports:
//   clk_i, rst_i (async, active-low)
//   advance_i : one-cycle strobe, a CAM write happens this cycle
//   ptr_o     : slot the next miss will be written to
//   full_o    : every slot has been written at least once since reset
module cam_alloc_ptr
  import cam_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic advance_i,
  output idx_t ptr_o,
  output logic full_o
);

  localparam int unsigned CNT_W = IDX_W + 1;

  idx_t             ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;

  // Next pointer/count; full is precomputed so it can be registered.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (advance_i) begin
      ptr_d = (ptr_q == IDX_W'(DEPTH - 1)) ? '0 : ptr_q + IDX_W'(1);
      if (count_q != CNT_W'(DEPTH)) begin
        count_d = count_q + CNT_W'(1);
      end
    end
    full_d = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign full_o = full_q;

endmodule

// File: rtl/cam_lookup_ctrl.sv
// Lookup-or-insert controller in front of a DEPTH-entry CAM. Each accepted
// key is searched; a miss is written to the round-robin allocation slot.
// The response carries the entry index with hit/evict flags.
// Ports:
//   clk_i, rst_i (async, active-low)
//   bus_io              : request/response handshake (slave side)
//   full_o              : all entries written since reset
//   cam_search_*        : CAM search strobe/key and registered result
//   cam_write_*         : CAM write strobe/index/data
module cam_lookup_ctrl
  import cam_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  cam_lookup_ctrl_if.slave   bus_io,
  output logic               full_o,
  output logic               cam_search_enable_o,
  output key_t               cam_search_data_o,
  input  logic               cam_search_valid_i,
  input  idx_t               cam_search_index_i,
  output logic               cam_write_enable_o,
  output idx_t               cam_write_index_o,
  output key_t               cam_write_data_o
);

  state_e state_q, state_d;
  key_t   key_q, key_d;
  rsp_t   rsp_q, rsp_d;
  logic   req_ready_q, req_ready_d;
  logic   rsp_valid_q, rsp_valid_d;
  logic   search_en_q, search_en_d;
  logic   write_en_q, write_en_d;

  idx_t   alloc_ptr;
  logic   alloc_full;
  logic   alloc_advance;

  // The pointer advances on the edge that ends WRITE, i.e. with the CAM write.
  assign alloc_advance = (state_q == WRITE);

  cam_alloc_ptr u_alloc (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .advance_i (alloc_advance),
    .ptr_o     (alloc_ptr),
    .full_o    (alloc_full)
  );

  // Next state, captured fields, and registered Moore outputs decoded from
  // the next state so each strobe is high exactly while in its state.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rsp_d   = rsp_q;

    case (state_q)
      IDLE: begin
        if (bus_io.req_valid) begin
          key_d   = bus_io.req_key;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (cam_search_valid_i) begin
          rsp_d.index = cam_search_index_i;
          rsp_d.hit   = 1'b1;
          rsp_d.evict = 1'b0;
          state_d     = RESP;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Evict reflects occupancy before this write lands.
        rsp_d.index = alloc_ptr;
        rsp_d.hit   = 1'b0;
        rsp_d.evict = alloc_full;
        state_d     = RESP;
      end
      RESP: begin
        if (bus_io.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
    search_en_d = (state_d == SEARCH);
    write_en_d  = (state_d == WRITE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      key_q       <= '0;
      rsp_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      search_en_q <= 1'b0;
      write_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      rsp_q       <= rsp_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      search_en_q <= search_en_d;
      write_en_q  <= write_en_d;
    end
  end

  assign bus_io.req_ready    = req_ready_q;
  assign bus_io.rsp_valid    = rsp_valid_q;
  assign bus_io.rsp_data     = rsp_q;

  assign full_o              = alloc_full;
  assign cam_search_enable_o = search_en_q;
  assign cam_search_data_o   = key_q;
  assign cam_write_enable_o  = write_en_q;
  assign cam_write_index_o   = alloc_ptr;
  assign cam_write_data_o    = key_q;

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Bench for cam_lookup_ctrl: behavioural CAM, table of directed requests,
// and hand-written sequences for stall, back-to-back and mid-write reset.
module tb_cam_lookup_ctrl;
  import cam_pkg::*;

  logic clk_i;
  logic rst_i;
  logic full;
  logic cam_search_enable;
  key_t cam_search_data;
  logic cam_search_valid;
  idx_t cam_search_index;
  logic cam_write_enable;
  idx_t cam_write_index;
  key_t cam_write_data;

  cam_lookup_ctrl_if ifc ();

  cam_lookup_ctrl dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .bus_io              (ifc),
    .full_o              (full),
    .cam_search_enable_o (cam_search_enable),
    .cam_search_data_o   (cam_search_data),
    .cam_search_valid_i  (cam_search_valid),
    .cam_search_index_i  (cam_search_index),
    .cam_write_enable_o  (cam_write_enable),
    .cam_write_index_o   (cam_write_index),
    .cam_write_data_o    (cam_write_data)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc_cnt = 0;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  // Behavioural CAM: registered lowest-index search result, write on edge.
  logic cam_clr;
  logic cam_v [DEPTH];
  key_t cam_d [DEPTH];

  function automatic logic [IDX_W:0] cam_find(input key_t k);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cam_v[i] && cam_d[i] == k) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  always @(posedge clk_i) begin
    if (cam_clr) begin
      for (int i = 0; i < DEPTH; i++) cam_v[i] <= 1'b0;
      cam_search_valid <= 1'b0;
      cam_search_index <= '0;
    end else begin
      if (cam_search_enable) begin
        {cam_search_valid, cam_search_index} <= cam_find(cam_search_data);
      end
      if (cam_write_enable) begin
        cam_v[cam_write_index] <= 1'b1;
        cam_d[cam_write_index] <= cam_write_data;
      end
    end
  end

  int overlap = 0;
  always @(negedge clk_i) begin
    if (cam_search_enable && cam_write_enable) overlap <= overlap + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Results of the last do_req.
  int   r_lat, r_ns, r_nw, r_acc;
  idx_t r_idx, r_widx;
  logic r_hit, r_ev;
  key_t r_sdata, r_wdata;

  // Issue one request with rsp_ready high; cycle 1 is the cycle after accept.
  task automatic do_req(input key_t key);
    int n;
    n = 0;
    while (!ifc.req_ready && n < 20) begin
      @(posedge clk_i); #1; n++;
    end
    chk("req_ready_wait", 64'(ifc.req_ready), 64'd1);
    ifc.req_valid = 1'b1;
    ifc.req_key   = key;
    @(posedge clk_i); #1;
    ifc.req_valid = 1'b0;
    r_acc = cyc_cnt;
    r_lat = 1; r_ns = 0; r_nw = 0;
    r_widx = '0; r_sdata = '0; r_wdata = '0;
    while (r_lat < 12) begin
      if (cam_search_enable) begin r_ns++; r_sdata = cam_search_data; end
      if (cam_write_enable) begin
        r_nw++; r_widx = cam_write_index; r_wdata = cam_write_data;
      end
      if (ifc.rsp_valid) break;
      @(posedge clk_i); #1; r_lat++;
    end
    r_idx = ifc.rsp_data.index;
    r_hit = ifc.rsp_data.hit;
    r_ev  = ifc.rsp_data.evict;
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0; cam_clr = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1; cam_clr = 1'b0;
    @(posedge clk_i); #1;
  endtask

  typedef struct {
    logic rst_before;
    key_t key;
    int   lat;
    idx_t idx;
    logic hit;
    logic evict;
    int   nwr;
    logic full;
  } vec_t;

  localparam int NV = 38;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int errs;
    int acc_a;
    string nm;

    vecs[0]  = '{1'b0, 32'hDEAD_BEEF, 4, 5'd0, 1'b0, 1'b0, 1, 1'b0};
    vecs[1]  = '{1'b0, 32'hDEAD_BEEF, 3, 5'd0, 1'b1, 1'b0, 0, 1'b0};
    for (int i = 0; i < 32; i++) begin
      vecs[2+i] = '{(i == 0), 32'(32'h100 + i), 4, 5'(i), 1'b0, 1'b0, 1, (i == 31)};
    end
    vecs[34] = '{1'b0, 32'h200, 4, 5'd0, 1'b0, 1'b1, 1, 1'b1};
    vecs[35] = '{1'b0, 32'h101, 3, 5'd1, 1'b1, 1'b0, 0, 1'b1};
    vecs[36] = '{1'b0, 32'h100, 4, 5'd1, 1'b0, 1'b1, 1, 1'b1};
    vecs[37] = '{1'b0, 32'h200, 3, 5'd0, 1'b1, 1'b0, 0, 1'b1};

    rst_i = 1'b0; cam_clr = 1'b1;
    ifc.req_valid = 1'b0; ifc.req_key = '0; ifc.rsp_ready = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req_ready",  64'(ifc.req_ready), 64'd1);
    chk("rst_rsp_valid",  64'(ifc.rsp_valid), 64'd0);
    chk("rst_search_en",  64'(cam_search_enable), 64'd0);
    chk("rst_write_en",   64'(cam_write_enable), 64'd0);
    chk("rst_full",       64'(full), 64'd0);
    chk("rst_write_idx",  64'(cam_write_index), 64'd0);
    chk("rst_search_dat", 64'(cam_search_data), 64'd0);
    chk("rst_rsp_data",   64'(ifc.rsp_data), 64'd0);
    rst_i = 1'b1; cam_clr = 1'b0;
    @(posedge clk_i); #1;

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst_before) do_reset();
      do_req(vecs[i].key);
      nm = $sformatf("v%0d", i);
      chk({nm, "_lat"},   64'(r_lat), 64'(vecs[i].lat));
      chk({nm, "_idx"},   64'(r_idx), 64'(vecs[i].idx));
      chk({nm, "_hit"},   64'(r_hit), 64'(vecs[i].hit));
      chk({nm, "_evict"}, 64'(r_ev),  64'(vecs[i].evict));
      chk({nm, "_nsrch"}, 64'(r_ns),  64'd1);
      chk({nm, "_sdata"}, 64'(r_sdata), 64'(vecs[i].key));
      chk({nm, "_nwr"},   64'(r_nw),  64'(vecs[i].nwr));
      if (vecs[i].nwr == 1) begin
        chk({nm, "_widx"},  64'(r_widx),  64'(vecs[i].idx));
        chk({nm, "_wdata"}, 64'(r_wdata), 64'(vecs[i].key));
      end
      chk({nm, "_full"},  64'(full), 64'(vecs[i].full));
    end

    // Response stalled for 10 cycles while a second request is offered.
    ifc.rsp_ready = 1'b0;
    ifc.req_valid = 1'b1;
    ifc.req_key   = 32'h200;
    @(posedge clk_i); #1;
    ifc.req_key = 32'h300;
    n = 0;
    while (!ifc.rsp_valid && n < 10) begin
      @(posedge clk_i); #1; n++;
    end
    chk("stall_rsp_seen", 64'(ifc.rsp_valid), 64'd1);
    chk("stall_idx",      64'(ifc.rsp_data.index), 64'd0);
    chk("stall_hit",      64'(ifc.rsp_data.hit), 64'd1);
    errs = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_i); #1;
      if (ifc.rsp_valid !== 1'b1 || ifc.rsp_data.index !== 5'd0 ||
          ifc.rsp_data.hit !== 1'b1 || ifc.req_ready !== 1'b0 ||
          cam_search_enable !== 1'b0) errs++;
    end
    chk("stall_stable_errs", 64'(errs), 64'd0);
    ifc.req_valid = 1'b0;
    ifc.rsp_ready = 1'b1;
    @(posedge clk_i); #1;
    chk("stall_rsp_drop",  64'(ifc.rsp_valid), 64'd0);
    chk("stall_req_ready", 64'(ifc.req_ready), 64'd1);
    @(posedge clk_i); #1;
    chk("stall_no_search", 64'(cam_search_enable), 64'd0);

    // Back-to-back hits.
    do_req(32'h102);
    acc_a = r_acc;
    chk("b2b0_lat",   64'(r_lat), 64'd3);
    chk("b2b0_idx",   64'(r_idx), 64'd2);
    chk("b2b0_nsrch", 64'(r_ns),  64'd1);
    do_req(32'h103);
    chk("b2b1_lat",   64'(r_lat), 64'd3);
    chk("b2b1_idx",   64'(r_idx), 64'd3);
    chk("b2b1_nsrch", 64'(r_ns),  64'd1);
    chk("b2b1_nwr",   64'(r_nw),  64'd0);
    chk("b2b_spacing", 64'(r_acc - acc_a), 64'd4);

    // Reset pulsed during WRITE.
    ifc.req_valid = 1'b1;
    ifc.req_key   = 32'h400;
    @(posedge clk_i); #1;
    ifc.req_valid = 1'b0;
    n = 0;
    while (!cam_write_enable && n < 10) begin
      @(posedge clk_i); #1; n++;
    end
    chk("rw_saw_write", 64'(cam_write_enable), 64'd1);
    rst_i = 1'b0;
    #1;
    chk("rw_write_drop", 64'(cam_write_enable), 64'd0);
    chk("rw_rsp_valid",  64'(ifc.rsp_valid), 64'd0);
    chk("rw_req_ready",  64'(ifc.req_ready), 64'd1);
    chk("rw_full",       64'(full), 64'd0);
    #3;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    do_req(32'h500);
    chk("rw_next_lat",   64'(r_lat),  64'd4);
    chk("rw_next_idx",   64'(r_idx),  64'd0);
    chk("rw_next_widx",  64'(r_widx), 64'd0);
    chk("rw_next_hit",   64'(r_hit),  64'd0);
    chk("rw_next_evict", 64'(r_ev),   64'd0);
    chk("rw_next_full",  64'(full),   64'd0);

    chk("strobe_overlap", 64'(overlap), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
